// File: rtl/learn_costs_table_if.sv
// Packet-field / memory-port bundle between the decoder, the shared mem block and learn_costs_table.
interface learn_costs_table_if #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic [WORD_WIDTH-1:0] fsourceID;
    logic [WORD_WIDTH-1:0] fbatteryStat;
    logic [WORD_WIDTH-1:0] fValue;
    logic [WORD_WIDTH-1:0] fclusterID;
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] mem_data_out;
    logic [WORD_WIDTH-1:0] mem_data_in;
    logic                  reinit;
    logic                  done;
    logic                  table_full;
    logic                  busy;

    modport master (
        output start, fsourceID, fbatteryStat, fValue, fclusterID, mem_data_out,
        input  address, wr_en, mem_data_in, reinit, done, table_full, busy
    );

    modport slave (
        input  start, fsourceID, fbatteryStat, fValue, fclusterID, mem_data_out,
        output address, wr_en, mem_data_in, reinit, done, table_full, busy
    );
endinterface

// File: rtl/learn_costs_table.sv
// Neighbour-cost table updater: scans the shared-memory neighbour table for a packet's source,
// then updates it with a shift-based learning rate, appends it, drops it or evicts the costliest entry.
module learn_costs_table #(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    MAX_NEIGHBORS = 8,
    parameter logic [ADDR_WIDTH-1:0] TABLE_BASE    = 16'h0100,
    parameter int                    ALPHA_SHIFT   = 1,
    parameter int                    FULL_MODE     = 0
) (
    input logic                clock,
    input logic                nrst,
    learn_costs_table_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_CNT, SCAN_ID, SCAN_VAL, RD_OLD, WRITE, DONE, WAIT_REL
    } state_t;

    localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_NEIGHBORS);

    state_t                r_state;
    logic [1:0]            r_phase;
    logic [WORD_WIDTH-1:0] r_srcId, r_bat, r_val, r_cluster;
    logic [WORD_WIDTH-1:0] r_count, r_idx, r_target, r_oldVal, r_maxVal, r_maxIdx;
    logic                  r_match, r_isFound, r_isAppend, r_reinit, r_full;
    logic [2:0]            r_step;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [WORD_WIDTH-1:0] r_dataOut;
    logic                  r_wrEn, r_reinitOut, r_done, r_tableFull, r_busy;

    logic signed [WORD_WIDTH:0] w_diff, w_shift;
    logic [WORD_WIDTH-1:0]      w_newVal, w_nextIdx, w_maxIdx, w_nextData;
    logic                       w_hit, w_lastEntry, w_maxTake;
    logic [2:0]                 w_nextStep, w_lastStep;

    // Field 4 is the count word; fields 0..3 are ID, battery, value, cluster of entry idx.
    function automatic logic [ADDR_WIDTH-1:0] fieldAddr(input logic [WORD_WIDTH-1:0] idx,
                                                        input logic [2:0] fld);
        logic [ADDR_WIDTH-1:0] a;
        if (fld == 3'd4)
            a = TABLE_BASE;
        else
            a = TABLE_BASE + ADDR_WIDTH'(2) + (ADDR_WIDTH'(idx) << 3) + ADDR_WIDTH'({fld, 1'b0});
        return a;
    endfunction

    assign w_diff      = $signed({1'b0, r_val}) - $signed({1'b0, r_oldVal});
    assign w_shift     = w_diff >>> ALPHA_SHIFT;
    assign w_newVal    = r_oldVal + w_shift[WORD_WIDTH-1:0];
    assign w_hit       = (FULL_MODE != 0) ? r_match : (bus.mem_data_out == r_srcId);
    assign w_nextIdx   = r_idx + WORD_WIDTH'(1);
    assign w_lastEntry = (w_nextIdx == r_count);
    assign w_maxTake   = (r_idx == '0) || (bus.mem_data_out > r_maxVal);
    assign w_maxIdx    = w_maxTake ? r_idx : r_maxIdx;
    assign w_nextStep  = r_step + 3'd1;
    assign w_lastStep  = r_isAppend ? 3'd4 : 3'd3;

    always_comb begin
        w_nextData = r_count + WORD_WIDTH'(1);
        case (w_nextStep)
            3'd1:    w_nextData = r_bat;
            3'd2:    w_nextData = r_isFound ? w_newVal : r_val;
            3'd3:    w_nextData = r_cluster;
            default: w_nextData = r_count + WORD_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_srcId     <= '0;
            r_bat       <= '0;
            r_val       <= '0;
            r_cluster   <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_target    <= '0;
            r_oldVal    <= '0;
            r_maxVal    <= '0;
            r_maxIdx    <= '0;
            r_match     <= 1'b0;
            r_isFound   <= 1'b0;
            r_isAppend  <= 1'b0;
            r_reinit    <= 1'b0;
            r_full      <= 1'b0;
            r_step      <= '0;
            r_address   <= '0;
            r_dataOut   <= '0;
            r_wrEn      <= 1'b0;
            r_reinitOut <= 1'b0;
            r_done      <= 1'b0;
            r_tableFull <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_srcId    <= bus.fsourceID;
                        r_bat      <= bus.fbatteryStat;
                        r_val      <= bus.fValue;
                        r_cluster  <= bus.fclusterID;
                        r_idx      <= '0;
                        r_isFound  <= 1'b0;
                        r_isAppend <= 1'b0;
                        r_reinit   <= 1'b0;
                        r_full     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_address  <= TABLE_BASE;
                        r_phase    <= 2'd0;
                        r_state    <= RD_CNT;
                    end
                end
                // Phase 2 is a decision cycle once the clamped count is registered.
                RD_CNT: begin
                    if (r_phase == 2'd0) begin
                        r_phase <= 2'd1;
                    end else if (r_phase == 2'd1) begin
                        r_count <= (bus.mem_data_out > MAX_W) ? MAX_W : bus.mem_data_out;
                        r_phase <= 2'd2;
                    end else if (r_count == '0) begin
                        r_target   <= r_count;
                        r_isAppend <= 1'b1;
                        r_reinit   <= 1'b1;
                        r_step     <= 3'd0;
                        r_address  <= fieldAddr(r_count, 3'd0);
                        r_dataOut  <= r_srcId;
                        r_wrEn     <= 1'b1;
                        r_state    <= WRITE;
                    end else begin
                        r_address <= fieldAddr('0, 3'd0);
                        r_phase   <= 2'd0;
                        r_state   <= SCAN_ID;
                    end
                end
                SCAN_ID, SCAN_VAL: begin
                    if (r_phase == 2'd0) begin
                        r_phase <= 2'd1;
                    end else if (r_state == SCAN_ID && FULL_MODE != 0) begin
                        r_match   <= (bus.mem_data_out == r_srcId);
                        r_address <= fieldAddr(r_idx, 3'd2);
                        r_phase   <= 2'd0;
                        r_state   <= SCAN_VAL;
                    end else begin
                        if (FULL_MODE != 0 && w_maxTake) begin
                            r_maxVal <= bus.mem_data_out;
                            r_maxIdx <= r_idx;
                        end
                        r_phase <= 2'd0;
                        if (w_hit) begin
                            r_target  <= r_idx;
                            r_isFound <= 1'b1;
                            r_address <= fieldAddr(r_idx, 3'd2);
                            r_state   <= RD_OLD;
                        end else if (!w_lastEntry) begin
                            r_idx     <= w_nextIdx;
                            r_address <= fieldAddr(w_nextIdx, 3'd0);
                            r_state   <= SCAN_ID;
                        end else if (r_count < MAX_W) begin
                            r_target   <= r_count;
                            r_isAppend <= 1'b1;
                            r_reinit   <= 1'b1;
                            r_step     <= 3'd0;
                            r_address  <= fieldAddr(r_count, 3'd0);
                            r_dataOut  <= r_srcId;
                            r_wrEn     <= 1'b1;
                            r_state    <= WRITE;
                        end else if (FULL_MODE == 0) begin
                            r_done      <= 1'b1;
                            r_tableFull <= 1'b1;
                            r_reinitOut <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_target  <= w_maxIdx;
                            r_reinit  <= 1'b1;
                            r_full    <= 1'b1;
                            r_step    <= 3'd0;
                            r_address <= fieldAddr(w_maxIdx, 3'd0);
                            r_dataOut <= r_srcId;
                            r_wrEn    <= 1'b1;
                            r_state   <= WRITE;
                        end
                    end
                end
                // Reads old value (phases 0-1) then old cluster (phases 2-3) of the matched entry.
                RD_OLD: begin
                    if (r_phase == 2'd1) begin
                        r_oldVal  <= bus.mem_data_out;
                        r_address <= fieldAddr(r_target, 3'd3);
                        r_phase   <= 2'd2;
                    end else if (r_phase == 2'd3) begin
                        r_reinit  <= (bus.mem_data_out != r_cluster);
                        r_step    <= 3'd1;
                        r_address <= fieldAddr(r_target, 3'd1);
                        r_dataOut <= r_bat;
                        r_wrEn    <= 1'b1;
                        r_state   <= WRITE;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
                WRITE: begin
                    if (r_step == w_lastStep) begin
                        r_wrEn      <= 1'b0;
                        r_done      <= 1'b1;
                        r_reinitOut <= r_reinit;
                        r_tableFull <= r_full;
                        r_state     <= DONE;
                    end else begin
                        r_step    <= w_nextStep;
                        r_address <= fieldAddr(r_target, w_nextStep);
                        r_dataOut <= w_nextData;
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_reinitOut <= 1'b0;
                    r_tableFull <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!bus.start)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.address     = r_address;
    assign bus.wr_en       = r_wrEn;
    assign bus.mem_data_in = r_dataOut;
    assign bus.reinit      = r_reinitOut;
    assign bus.done        = r_done;
    assign bus.table_full  = r_tableFull;
    assign bus.busy        = r_busy;
endmodule

// File: doc/learn_costs_table.md
# learn_costs_table

Parametrised neighbour-cost table updater for the cluster-routing node. On each `start` it takes one received packet's fields (source ID, battery status, cost value, cluster ID), then scans the neighbour table in shared memory. It updates a known neighbour's entry with a shift-based learning-rate cost update, or appends a new neighbour. When the table is full it either drops the packet or evicts the highest-cost entry. It sits between the packet decoder and the shared `mem` block and drives the memory port alone while busy.

## Interface
- `WORD_WIDTH`, 16: data width of every table field and memory word.
- `ADDR_WIDTH`, 16: memory address width (byte address).
- `MAX_NEIGHBORS`, 8: table capacity in entries (1..255).
- `TABLE_BASE`, 16'h0100: byte address of the table's count word.
- `ALPHA_SHIFT`, 1: learning-rate shift (0 = overwrite with new value).
- `FULL_MODE`, 0: behaviour when full: 0 = drop the packet, 1 = replace the highest-cost entry.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `nrst`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled in IDLE only.
- `fsourceID`, `fbatteryStat`, `fValue`, `fclusterID`  in  WORD_WIDTH each  packet fields; latched on the accepting edge.
- `address`  out  ADDR_WIDTH  memory byte address.
- `wr_en`  out  1  memory write strobe.
- `mem_data_out`  in  WORD_WIDTH  memory read data; valid one cycle after `address`.
- `mem_data_in`  out  WORD_WIDTH  memory write data.
- `reinit`  out  1  one-cycle pulse, coincident with `done`; topology changed.
- `done`  out  1  one-cycle completion pulse.
- `table_full`  out  1  one-cycle pulse, coincident with `done`, when a new neighbour was not stored.
- `busy`  out  1  high from the accepting edge until the WAIT_REL state.

## Operation
- Table layout:
  - count word at `TABLE_BASE`.
  - entry i occupies 4 words at `TABLE_BASE + 2 + 8*i`, offsets +0 ID, +2 battery, +4 value, +6 cluster.
- A stored count greater than `MAX_NEIGHBORS` is treated as `MAX_NEIGHBORS`.
- States: IDLE, RD_CNT, SCAN_ID, SCAN_VAL (only when FULL_MODE=1), RD_OLD, WRITE, DONE, WAIT_REL.
- Memory access cost:
  - each read takes 2 cycles: issue the address, then capture the data.
  - each write takes 1 cycle with `wr_en` = 1.
- Scan: walk entries 0..count-1 comparing the stored ID with `fsourceID`. The scan stops at the first match.
  - FULL_MODE=1: each entry's value is also read. The scan tracks the index of the strictly largest value; on a tie the lowest index is kept.
- Found (index k):
  - read the old value and the old cluster.
  - write battery = `fbatteryStat`.
  - write value = old + ((fValue − old) >>> ALPHA_SHIFT). The subtraction is done in WORD_WIDTH+1 signed arithmetic with an arithmetic shift; the result is truncated to WORD_WIDTH (it is always in range).
  - write cluster = `fclusterID`.
  - `reinit` = 1 iff the old cluster ≠ `fclusterID`.
- Not found, count < MAX:
  - write ID, battery, value = `fValue` and cluster to entry `count`.
  - write count+1.
  - `reinit` = 1.
- Not found, full, FULL_MODE=0: no writes; `table_full` = 1; `reinit` = 0.
- Not found, full, FULL_MODE=1:
  - overwrite all 4 fields of the max-value entry with the packet fields; the count is unchanged.
  - `reinit` = 1; `table_full` = 1.
- DONE lasts 1 cycle. It moves to WAIT_REL, which returns to IDLE once `start` = 0, so a held `start` triggers exactly one transaction.
- `start` is ignored outside IDLE.

## Timing
- Reset values: `address` = 0, `wr_en` = 0, `mem_data_in` = 0, `reinit` = 0, `done` = 0, `table_full` = 0, `busy` = 0, state IDLE.
- Reset mid-operation:
  - state returns to IDLE at the next edge and `wr_en` drops at that edge.
  - writes already committed stay in memory.
  - no `done` is produced.
- S = 2 per scanned entry (FULL_MODE=0) or 4 (FULL_MODE=1). Edge 0 is the edge that samples `start`; `done` is high in the cycle following edge N, where:
  - found at k: N = 10 + S·(k+1).
  - append at count c: N = 8 + S·c.
  - full, drop: N = 3 + S·MAX.
  - full, replace: N = 7 + S·MAX.
- `wr_en` is never high during read cycles, nor in DONE or WAIT_REL.

## Test plan
All scenarios use defaults unless stated.
- Found update: count=3; entry1 = {31, 2, 20, 11}; packet {31, 5, 10, 11} -> entry1 = {31, 5, 15, 11}, `reinit` = 0, `done` after edge 14.
- Cluster change: same as above with `fclusterID` = 12 -> entry1 cluster = 12, value = 15, `reinit` = 1 with `done`.
- Append: count=3, packet {1, 5, 10, 11} with no ID match -> bytes 0x011A..0x0120 = 1, 5, 10, 11; count = 4; `reinit` = 1; `done` after edge 14.
- Full drop: count=8, no match -> `wr_en` never asserted, `table_full` = 1, `done` after edge 19.
- Full replace: FULL_MODE=1, count=8, entry i value = 10·(i+1), plus a duplicate 80 injected at entry 7 and entry 5 -> entry 5 overwritten, count stays 8, `done` after edge 39.
- Control:
  - `start` held high for 100 cycles -> exactly one `done`.
  - `nrst` low during SCAN_ID -> IDLE next edge, `wr_en` = 0, no `done`.
  - a new `start` afterwards completes normally.
